// File: rtl/imem_loader_if.sv
// Byte-stream and imem-write bundle between the host byte source, the loader and imem.
// The loader masters the imem write port, so it takes the master modport.
interface imem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err_len;
    logic        err_csum;

    modport master (
        input  start, rx_data, rx_valid,
        output rx_ready, we, waddr, wdata, cpu_hold, busy, done, err_len, err_csum
    );

    modport slave (
        output start, rx_data, rx_valid,
        input  rx_ready, we, waddr, wdata, cpu_hold, busy, done, err_len, err_csum
    );
endinterface

// File: rtl/imem_loader.sv
// Program loader: parses a framed byte stream (length, payload, checksum), writes
// little-endian words into imem and holds the CPU until a good image is in place.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter logic [31:0] BASE_ADDR     = 32'h0,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input logic           clk,
    input logic           reset,
    imem_loader_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_e;

    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    state_e      state_q;
    logic [15:0] n_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [7:0]  sum_q;
    logic [23:0] lanes_q;
    logic        rx_ready_q;
    logic        we_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic        cpu_hold_q;
    logic        busy_q;
    logic        done_q;
    logic        err_len_q;
    logic        err_csum_q;

    logic        xfer;
    logic [15:0] n_full;

    assign xfer   = bus.rx_valid & rx_ready_q;
    assign n_full = {bus.rx_data, n_q[7:0]};

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge value of every register, independent of order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            sum_q      <= '0;
            lanes_q    <= '0;
            rx_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cpu_hold_q <= HOLD_AT_RESET;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
            err_csum_q <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        state_q    <= S_LEN_LO;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        sum_q      <= '0;
                        done_q     <= 1'b0;
                        err_len_q  <= 1'b0;
                        err_csum_q <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        busy_q     <= 1'b1;
                        rx_ready_q <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        n_q[7:0] <= bus.rx_data;
                        state_q  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        n_q <= n_full;
                        // Oversized images are rejected before any write is issued.
                        if ({1'b0, n_full} > MAX_WORDS) begin
                            state_q    <= S_ERR;
                            err_len_q  <= 1'b1;
                            busy_q     <= 1'b0;
                            rx_ready_q <= 1'b0;
                        end else if (n_full == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        sum_q      <= sum_q + bus.rx_data;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: lanes_q[7:0]   <= bus.rx_data;
                            2'd1: lanes_q[15:8]  <= bus.rx_data;
                            2'd2: lanes_q[23:16] <= bus.rx_data;
                            default: begin
                                wdata_q    <= {bus.rx_data, lanes_q};
                                waddr_q    <= BASE_ADDR + 32'({word_idx_q, 2'b00});
                                we_q       <= 1'b1;
                                rx_ready_q <= 1'b0;
                                state_q    <= S_WRITE;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    rx_ready_q <= 1'b1;
                    if (word_idx_q == n_q - 16'd1) begin
                        state_q <= S_CSUM;
                    end else begin
                        word_idx_q <= word_idx_q + 16'd1;
                        state_q    <= S_DATA;
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (bus.rx_data == sum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q    <= S_ERR;
                            err_csum_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.we       = we_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.cpu_hold = cpu_hold_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err_len  = err_len_q;
    assign bus.err_csum = err_csum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, directed corner cases
// and random frames compared against a frame-level reference model.
module tb_imem_loader;

    localparam int          MAX_WORDS = 256;
    localparam logic [31:0] BASE      = 32'h0;

    typedef logic [7:0]  bq_t[$];
    typedef logic [63:0] wr_t;
    typedef wr_t         wq_t[$];

    typedef struct {
        int         n;
        int         len_field;
        logic [7:0] csum_delta;
        int         gap;
        bit         exp_done;
        bit         exp_el;
        bit         exp_ec;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    wq_t  cap_q;

    imem_loader_if intf ();

    imem_loader #(
        .ADDR_WIDTH   (8),
        .BASE_ADDR    (BASE),
        .HOLD_AT_RESET(1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (intf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture every write pulse; the byte source must be stalled while it is up.
    always @(negedge clk) begin
        if (reset === 1'b1 && intf.we === 1'b1) begin
            cap_q.push_back({intf.waddr, intf.wdata});
            check("rx_ready low during write", intf.rx_ready, 1'b0);
        end
    end

    // Frame-level reference: decode the byte list directly into writes and flags.
    function automatic void model(input bq_t s, output wq_t w, output bit d, output bit el,
                                  output bit ec);
        int         n;
        logic [7:0] sum;
        logic [31:0] word;
        w  = {};
        d  = 0;
        el = 0;
        ec = 0;
        n  = int'(s[0]) + 256 * int'(s[1]);
        if (n > MAX_WORDS) begin
            el = 1;
            return;
        end
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                word[8*j +: 8] = s[2 + 4*i + j];
                sum            = sum + s[2 + 4*i + j];
            end
            w.push_back({BASE + 32'(4 * i), word});
        end
        if (s[2 + 4*n] == sum) d = 1;
        else ec = 1;
    endfunction

    function automatic bq_t make_frame(input int n, input int len_field, input logic [7:0] delta);
        bq_t        q;
        int         len;
        logic [7:0] sum;
        logic [7:0] b;
        len = (len_field < 0) ? n : len_field;
        q.push_back(8'(len));
        q.push_back(8'(len >> 8));
        if (len > MAX_WORDS) return q;
        sum = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
            b   = 8'($urandom);
            sum = sum + b;
            q.push_back(b);
        end
        q.push_back(sum + delta);
        return q;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        int t;
        repeat (gap) begin
            @(negedge clk);
            intf.rx_valid = 1'b0;
            intf.start    = 1'b0;
        end
        @(negedge clk);
        intf.start    = 1'b0;
        intf.rx_valid = 1'b1;
        intf.rx_data  = b;
        t = 0;
        while (intf.rx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("rx_ready timeout", 1'b0, 1'b1);
        intf.start = with_start;
    endtask

    task automatic finish_frame();
        @(negedge clk);
        intf.rx_valid = 1'b0;
        intf.start    = 1'b0;
    endtask

    task automatic check_status(input string tag, input bit d, input bit el, input bit ec);
        check({tag, " done"}, intf.done, d);
        check({tag, " err_len"}, intf.err_len, el);
        check({tag, " err_csum"}, intf.err_csum, ec);
        check({tag, " cpu_hold"}, intf.cpu_hold, !d);
        check({tag, " busy"}, intf.busy, 1'b0);
        check({tag, " rx_ready"}, intf.rx_ready, 1'b0);
    endtask

    task automatic check_writes(input string tag, input wq_t ew);
        check({tag, " write count"}, cap_q.size(), ew.size());
        for (int i = 0; i < ew.size() && i < cap_q.size(); i++)
            check($sformatf("%s write %0d", tag, i), cap_q[i], ew[i]);
    endtask

    task automatic run_frame(input bq_t s, input int gap, input bit d, input bit el, input bit ec,
                             input string tag);
        wq_t ew;
        bit  md, mel, mec;
        model(s, ew, md, mel, mec);
        pulse_start();
        cap_q.delete();
        foreach (s[i]) send_byte(s[i], (gap > 0) ? int'($urandom_range(0, gap)) : 0, 1'b0);
        finish_frame();
        check_writes(tag, ew);
        check_status(tag, d, el, ec);
    endtask

    bq_t t1_bytes;
    wq_t t1_writes;

    initial begin
        vec_t       vecs[8];
        bq_t        s;
        wq_t        ew;
        bit         md, mel, mec;
        int         n;
        logic [7:0] delta;

        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        bq_t        s;
        wq_t        ew;
        bit         md, mel, mec;
        int         n;
        logic [7:0] delta;

        t1_bytes  = '{8'h02, 8'h00, 8'h33, 8'h82, 8'h20, 8'h00, 8'h33, 8'h82, 8'h20, 8'h40, 8'hEA};
        t1_writes = '{{32'h0, 32'h00208233}, {32'h4, 32'h40208233}};

        vecs[0] = '{n: 1,   len_field: -1,    csum_delta: 8'h00, gap: 0, exp_done: 1, exp_el: 0, exp_ec: 0};
        vecs[1] = '{n: 3,   len_field: -1,    csum_delta: 8'h00, gap: 3, exp_done: 1, exp_el: 0, exp_ec: 0};
        vecs[2] = '{n: 5,   len_field: -1,    csum_delta: 8'h01, gap: 2, exp_done: 0, exp_el: 0, exp_ec: 1};
        vecs[3] = '{n: 0,   len_field: -1,    csum_delta: 8'h00, gap: 0, exp_done: 1, exp_el: 0, exp_ec: 0};
        vecs[4] = '{n: 256, len_field: -1,    csum_delta: 8'h00, gap: 0, exp_done: 1, exp_el: 0, exp_ec: 0};
        vecs[5] = '{n: 0,   len_field: 257,   csum_delta: 8'h00, gap: 0, exp_done: 0, exp_el: 1, exp_ec: 0};
        vecs[6] = '{n: 0,   len_field: 65535, csum_delta: 8'h00, gap: 1, exp_done: 0, exp_el: 1, exp_ec: 0};
        vecs[7] = '{n: 2,   len_field: -1,    csum_delta: 8'hFF, gap: 1, exp_done: 0, exp_el: 0, exp_ec: 1};

        reset         = 1'b0;
        intf.start    = 1'b0;
        intf.rx_valid = 1'b0;
        intf.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset rx_ready", intf.rx_ready, 1'b0);
        check("reset we", intf.we, 1'b0);
        check("reset waddr/wdata", {intf.waddr, intf.wdata}, 64'h0);
        check("reset flags busy/done/errs", {intf.busy, intf.done, intf.err_len, intf.err_csum}, 4'b0);
        check("reset cpu_hold", intf.cpu_hold, 1'b1);
        reset = 1'b1;
        @(negedge clk);

        // T1: reference two-word image with literal expected words.
        run_frame(t1_bytes, 0, 1, 0, 0, "T1");
        check_writes("T1 literal", t1_writes);

        // T2: same payload, checksum off by one.
        s = t1_bytes;
        s[10] = 8'hEB;
        run_frame(s, 0, 0, 0, 1, "T2");
        check_writes("T2 literal", t1_writes);

        // T3: length 257 words exceeds a 256-word imem.
        run_frame('{8'h01, 8'h01}, 0, 0, 1, 0, "T3");
        repeat (3) @(negedge clk);
        check("T3 rx_ready stays low", intf.rx_ready, 1'b0);

        // T4: empty image, done right after the third accepted byte.
        run_frame('{8'h00, 8'h00, 8'h00}, 0, 1, 0, 0, "T4");

        // T5: T1 stream with random gaps; bytes held across the write cycle.
        run_frame(t1_bytes, 3, 1, 0, 0, "T5");
        check_writes("T5 literal", t1_writes);

        // start while busy is ignored; start alongside the checksum byte is ignored too.
        pulse_start();
        cap_q.delete();
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        finish_frame();
        pulse_start();
        check("busy start ignored busy", intf.busy, 1'b1);
        check("busy start ignored rx_ready", intf.rx_ready, 1'b1);
        for (int i = 2; i < 10; i++) send_byte(t1_bytes[i], 0, 1'b0);
        send_byte(t1_bytes[10], 0, 1'b1);
        finish_frame();
        check_writes("start-ignore", t1_writes);
        check_status("start-ignore", 1, 0, 0);
        repeat (2) @(negedge clk);
        check("csum start ignored busy", intf.busy, 1'b0);

        // T6: reset mid-payload, then a fresh load of the T1 image.
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(t1_bytes[i], 0, 1'b0);
        finish_frame();
        reset = 1'b0;
        #1;
        check("T6 async rx_ready", intf.rx_ready, 1'b0);
        check("T6 async busy/done", {intf.busy, intf.done}, 2'b00);
        check("T6 async cpu_hold", intf.cpu_hold, 1'b1);
        check("T6 async waddr/wdata", {intf.waddr, intf.wdata}, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame(t1_bytes, 0, 1, 0, 0, "T6");
        check_writes("T6 literal", t1_writes);

        foreach (vecs[k]) begin
            s = make_frame(vecs[k].n, vecs[k].len_field, vecs[k].csum_delta);
            run_frame(s, vecs[k].gap, vecs[k].exp_done, vecs[k].exp_el, vecs[k].exp_ec,
                      $sformatf("vec%0d", k));
        end

        for (int k = 0; k < 6; k++) begin
            n     = int'($urandom_range(0, 12));
            delta = ($urandom_range(0, 3) == 0) ? 8'(1 + $urandom_range(0, 254)) : 8'h00;
            s     = make_frame(n, -1, delta);
            model(s, ew, md, mel, mec);
            run_frame(s, 3, md, mel, mec, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
